pmod_ad1_rx: RTL

PMOD_AD1_RX -- requirements
Module: pmod_ad1_rx

---
 rtl/pmod_ad1_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pmod_ad1_rx.sv
`default_nettype none
// ============================================================================
//  Module   : pmod_ad1_rx
//  Purpose  : Receiver for a dual-channel PmodAD1 (two AD7476A-style ADCs
//             sharing ncs/sclk). On a start request it runs one 16-bit
//             serial frame, captures both channels MSB first, and presents
//             the 12-bit samples with a one-cycle valid pulse. A guaranteed
//             ncs-high quiet time separates consecutive frames.
//  Ports    : clk        - system clock, rising edge only
//             rst        - asynchronous reset, active low
//             start      - conversion request (looked at only when idle)
//             sdata0/1   - serial data from ADC channel 0 / 1
//             ncs        - active-low chip select to the ADCs
//             sclk       - serial clock to the ADCs, idles high
//             data0/1    - last complete 12-bit sample of each channel
//             valid      - one-cycle pulse when data0/data1 update
//             busy       - high while a frame or its quiet time is running
//             frame_err  - leading four bits of the last frame not all zero
//  Revision : 1.0 - initial release
// ============================================================================
module pmod_ad1_rx #(
  parameter int CLK_DIV      = 2,   // sclk half-period in clk cycles, 1..255
  parameter int QUIET_CYCLES = 4    // ncs-high time after a frame, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sdata0,
  input  logic        sdata1,
  output logic        ncs,
  output logic        sclk,
  output logic [11:0] data0,
  output logic [11:0] data1,
  output logic        valid,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [7:0] c_div_last   = 8'(CLK_DIV - 1);
  localparam logic [7:0] c_quiet_last = 8'(QUIET_CYCLES - 1);
  localparam logic [4:0] c_last_bit   = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_QUIET = 2'd2
  } state_t;

  // Registered state
  state_t      r_state;
  logic [7:0]  r_div;      // clk cycles into the current sclk half-period
  logic [4:0]  r_bitcnt;   // captures done in this frame, 0..16
  logic [7:0]  r_qcnt;     // cycles spent in QUIET
  logic        r_ncs;
  logic        r_sclk;
  logic [15:0] r_sh0;
  logic [15:0] r_sh1;
  logic [11:0] r_data0;
  logic [11:0] r_data1;
  logic        r_valid;
  logic        r_busy;
  logic        r_err;

  // Next-state values
  state_t      w_state_nxt;
  logic [7:0]  w_div_nxt;
  logic [4:0]  w_bitcnt_nxt;
  logic [7:0]  w_qcnt_nxt;
  logic        w_ncs_nxt;
  logic        w_sclk_nxt;
  logic [15:0] w_sh0_nxt;
  logic [15:0] w_sh1_nxt;
  logic [11:0] w_data0_nxt;
  logic [11:0] w_data1_nxt;
  logic        w_valid_nxt;
  logic        w_busy_nxt;
  logic        w_err_nxt;

  // Shift-register contents if a bit were captured at this edge
  logic [15:0] w_cap0;
  logic [15:0] w_cap1;

  // The oldest shift-register bit falls out on the next capture and is
  // never read back; the final frame is taken from w_cap* instead.
  logic w_unused_msb;
  assign w_unused_msb = r_sh0[15] ^ r_sh1[15];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_div    <= 8'd0;
      r_bitcnt <= 5'd0;
      r_qcnt   <= 8'd0;
      r_ncs    <= 1'b1;
      r_sclk   <= 1'b1;
      r_sh0    <= 16'd0;
      r_sh1    <= 16'd0;
      r_data0  <= 12'd0;
      r_data1  <= 12'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_qcnt   <= w_qcnt_nxt;
      r_ncs    <= w_ncs_nxt;
      r_sclk   <= w_sclk_nxt;
      r_sh0    <= w_sh0_nxt;
      r_sh1    <= w_sh1_nxt;
      r_data0  <= w_data0_nxt;
      r_data1  <= w_data1_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bitcnt_nxt = r_bitcnt;
    w_qcnt_nxt   = r_qcnt;
    w_sclk_nxt   = r_sclk;
    w_sh0_nxt    = r_sh0;
    w_sh1_nxt    = r_sh1;
    w_data0_nxt  = r_data0;
    w_data1_nxt  = r_data1;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = r_err;
    w_cap0       = {r_sh0[14:0], sdata0};
    w_cap1       = {r_sh1[14:0], sdata1};

    case (r_state)
      S_IDLE: begin
        w_sclk_nxt = 1'b1;
        if (start) begin
          w_state_nxt  = S_CONV;
          w_div_nxt    = 8'd0;
          w_bitcnt_nxt = 5'd0;
          w_sh0_nxt    = 16'd0;
          w_sh1_nxt    = 16'd0;
        end
      end

      S_CONV: begin
        if (r_div == c_div_last) begin
          w_div_nxt  = 8'd0;
          w_sclk_nxt = ~r_sclk;
          // A rising sclk is the sampling point: the ADC changed its
          // output on the preceding falling edge, so the data is stable.
          if (!r_sclk) begin
            w_sh0_nxt    = w_cap0;
            w_sh1_nxt    = w_cap1;
            w_bitcnt_nxt = r_bitcnt + 5'd1;
            // Last capture: publish the sample on the same edge so the
            // result carries no extra pipeline delay.
            if (r_bitcnt == c_last_bit) begin
              w_state_nxt = S_QUIET;
              w_qcnt_nxt  = 8'd0;
              w_sclk_nxt  = 1'b1;
              w_data0_nxt = w_cap0[11:0];
              w_data1_nxt = w_cap1[11:0];
              w_err_nxt   = (|w_cap0[15:12]) | (|w_cap1[15:12]);
              w_valid_nxt = 1'b1;
            end
          end
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end

      S_QUIET: begin
        w_sclk_nxt = 1'b1;
        if (r_qcnt == c_quiet_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_qcnt_nxt = r_qcnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_sclk_nxt  = 1'b1;
      end
    endcase

    // Chip select and busy follow the state being entered so they are
    // registered alongside it.
    w_ncs_nxt  = (w_state_nxt != S_CONV);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign ncs       = r_ncs;
  assign sclk      = r_sclk;
  assign data0     = r_data0;
  assign data1     = r_data1;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_err = r_err;

endmodule
`default_nettype wire
